mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle control unit for the 32-bit MIPS CPU. A Moore FSM sequences the shared datapath (PC, IR, register file, ALU, unified memory) through fetch, decode, execute, memory and writeback steps. A ready handshake stalls it on variable-latency memory. It sits inside `CPU` next to the datapath, driven by the same `Clock`.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum cycles a memory state waits for `MemReady` before raising `MemTimeout`.
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high; clears the FSM and counters immediately.
- `Opcode`  in  6  IR[31:26], read in DECODE.
- `Zero`  in  1  ALU zero flag, read in BRANCH.
- `MemReady`  in  1  memory completes the current access this cycle.
- `MemReq`  out  1  memory access requested.
- `MemWrite`  out  1  write strobe; valid only with `MemReq`.
- `IorD`  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- `IRWrite`, `PCWrite`, `RegWrite`  out  1 each  register write enables.
- `RegDst`, `MemtoReg`, `ALUSrcA`  out  1 each  datapath mux selects.
- `ALUSrcB`  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- `ALUOp`  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- `PCSrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `IllegalOp`  out  1  one-cycle pulse on an unknown opcode.
- `MemTimeout`  out  1  sticky flag; cleared only by `Reset`.
- `InstrRetired`  out  32  count of completed instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, JUMP.
- FETCH:
  - `MemReq`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSrc`=00.
  - `IRWrite` and `PCWrite` are asserted only in the cycle where `MemReady`=1; that same cycle moves to DECODE. Otherwise stay in FETCH.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - anything else → FETCH, with `IllegalOp` pulsed.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: `MemReq`=1, `IorD`=1. Moves to MEMWB on `MemReady`.
- MEMWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=1. Then FETCH.
- MEMWR: `MemReq`=1, `MemWrite`=1, `IorD`=1. Moves to FETCH on `MemReady`.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Then ALUWB.
- ALUWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Then FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Then ALUWB, but with `RegDst`=0. The destination choice is held in a registered `is_imm` bit set in DECODE.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCSrc`=01, `PCWrite`=`Zero`. Then FETCH.
- JUMP: `PCSrc`=10, `PCWrite`=1. Then FETCH.
- Any output not listed for a state is 0.
- `InstrRetired` increments on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JUMP. Illegal opcodes do not count. The counter wraps from 0xFFFFFFFF to 0.
- Memory wait: a wait counter runs while in FETCH, MEMRD or MEMWR with `MemReady`=0.
  - Timeout: when the counter reaches `MEM_WAIT_MAX`, set `MemTimeout` and return to FETCH without any write.
  - The counter clears on every state change.

## Timing
- Reset values: state FETCH, `InstrRetired`=0, `MemTimeout`=0, wait counter 0.
- While `Reset` is high, every output except `InstrRetired` is forced to 0.
- `Reset` asserted mid-instruction aborts it immediately; no pending write completes.
- Cycles per instruction with `MemReady` tied high: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.
- Each memory wait cycle adds one cycle.
- Outputs are decoded from the current state plus `MemReady` only. There is no combinational path from `Opcode` or `Zero` to any output except `PCWrite` in BRANCH.
- `MemReady` is ignored in states that do not assert `MemReq`.

## Structure
- Package `mips_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - the state enum;
  - the ALUOp, ALUSrcB and PCSrc encodings.
- Sub-module `mips_ctrl_outdec`: combinational state-to-control decode. It is shared with a future pipelined control variant.

## Test plan
- Reset mid-MEMRD with `MemReady` low → state FETCH; all outputs 0 while `Reset` is high; `InstrRetired` 0.
- Opcodes R-type, lw, sw, beq, addi, j with `MemReady`=1 → 4/5/4/3/4/3 cycles respectively, exact control vectors per state, `InstrRetired` reaches 6.
- beq with `Zero`=0, then `Zero`=1 → `PCWrite` 0, then 1, in BRANCH with `PCSrc`=01.
- FETCH with `MemReady` low for 3 cycles → `IRWrite`/`PCWrite` asserted only on cycle 4, DECODE on cycle 5.
- `MemReady` stuck low in MEMWR for 15 cycles → `MemTimeout`=1, FETCH next, no `RegWrite`, count unchanged.
- Opcode 111111 → one-cycle `IllegalOp`, return to FETCH, `InstrRetired` unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control: opcodes, FSM states, mux encodings.
// No logic; types and constants only.
// No flow control of its own.
package mips_pkg;

  // Opcode field IR[31:26] of the supported instructions
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIEX, JUMP
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full datapath control word produced each cycle
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // States that issue a memory access and may therefore wait on the memory
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational decode of FSM state (plus MemReady, Zero, is_imm) into the control word.
// Zero latency; purely combinational.
// MemReady only qualifies the FETCH write enables; Zero only affects PCWrite in BRANCH.
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  input  logic   is_imm,
  output ctrl_t  ctrl
);

  // Per-state control values; anything not set stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = ~is_imm;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_write  = zero;
      end
      JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback on a shared datapath.
// 3-5 cycles per instruction with MemReady high; control outputs are combinational from state.
// Stalls in FETCH/MEMRD/MEMWR until MemReady; gives up after MEM_WAIT_MAX cycles with sticky MemTimeout.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSrc,
  output logic        IllegalOp,
  output logic        MemTimeout,
  output logic [31:0] InstrRetired
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          is_imm;
  logic          is_sw;
  logic          illegal_q;
  logic          timeout_q;
  logic [31:0]   retired;
  logic          waiting;
  logic          wait_expired;
  ctrl_t         ctrl;
  ctrl_t         ctrl_g;

  // A memory state without MemReady is a wait cycle; the last allowed one aborts the access
  assign waiting      = is_mem_state(state) && !MemReady;
  assign wait_expired = waiting && (wait_cnt == CW'(MEM_WAIT_MAX - 1));

  // State sequencing, wait counter, retire counter and the sticky/pulse flags
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      is_imm    <= 1'b0;
      is_sw     <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired   <= '0;
    end else begin
      illegal_q <= 1'b0;
      wait_cnt  <= '0;
      if (wait_expired) begin
        state     <= FETCH;
        timeout_q <= 1'b1;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        case (state)
          FETCH: state <= DECODE;
          DECODE: begin
            // Instruction class is latched here so later states never look at Opcode
            is_imm <= (Opcode == OP_ADDI);
            is_sw  <= (Opcode == OP_SW);
            case (Opcode)
              OP_RTYPE:     state <= EXEC;
              OP_LW, OP_SW: state <= MEMADR;
              OP_BEQ:       state <= BRANCH;
              OP_ADDI:      state <= ADDIEX;
              OP_J:         state <= JUMP;
              default: begin
                state     <= FETCH;
                illegal_q <= 1'b1;
              end
            endcase
          end
          MEMADR:         state <= is_sw ? MEMWR : MEMRD;
          MEMRD:          state <= MEMWB;
          EXEC, ADDIEX:   state <= ALUWB;
          MEMWB, MEMWR, ALUWB, BRANCH, JUMP: begin
            state   <= FETCH;
            retired <= retired + 32'd1;
          end
          default:        state <= FETCH;
        endcase
      end
    end
  end

  mips_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (MemReady),
    .zero      (Zero),
    .is_imm    (is_imm),
    .ctrl      (ctrl)
  );

  // Reset forces every control output low, independent of the reset state's decode
  assign ctrl_g = Reset ? '0 : ctrl;

  assign MemReq       = ctrl_g.mem_req;
  assign MemWrite     = ctrl_g.mem_write;
  assign IorD         = ctrl_g.iord;
  assign IRWrite      = ctrl_g.ir_write;
  assign PCWrite      = ctrl_g.pc_write;
  assign RegWrite     = ctrl_g.reg_write;
  assign RegDst       = ctrl_g.reg_dst;
  assign MemtoReg     = ctrl_g.memto_reg;
  assign ALUSrcA      = ctrl_g.alu_src_a;
  assign ALUSrcB      = ctrl_g.alu_src_b;
  assign ALUOp        = ctrl_g.alu_op;
  assign PCSrc        = ctrl_g.pc_src;
  assign IllegalOp    = illegal_q & ~Reset;
  assign MemTimeout   = timeout_q & ~Reset;
  assign InstrRetired = retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: cycle-count table, per-cycle control words
// from an instruction-level micro-step model, random instruction streams, reset/timeout/illegal cases.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

  // Control words: {MemReq,MemWrite,IorD,IRWrite,PCWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
  localparam logic [14:0] FW   = {9'b100000000, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] FR   = {9'b100110000, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] DEC  = {9'b000000000, 2'b11, 2'b00, 2'b00};
  localparam logic [14:0] MADR = {9'b000000001, 2'b10, 2'b00, 2'b00};
  localparam logic [14:0] MRD  = {9'b101000000, 6'b0};
  localparam logic [14:0] MWB  = {9'b000001010, 6'b0};
  localparam logic [14:0] MWR  = {9'b111000000, 6'b0};
  localparam logic [14:0] EXE  = {9'b000000001, 2'b00, 2'b10, 2'b00};
  localparam logic [14:0] WBR  = {9'b000001100, 6'b0};
  localparam logic [14:0] WBI  = {9'b000001000, 6'b0};
  localparam logic [14:0] BR0  = {9'b000000001, 2'b00, 2'b01, 2'b01};
  localparam logic [14:0] BR1  = {9'b000010001, 2'b00, 2'b01, 2'b01};
  localparam logic [14:0] JMP  = {9'b000010000, 2'b00, 2'b00, 2'b10};

  logic        Clock = 1'b0, Reset = 1'b1, Zero = 1'b0, MemReady = 1'b0;
  logic [5:0]  Opcode = '0;
  logic        MemReq, MemWrite, IorD, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSrc;
  logic        IllegalOp, MemTimeout;
  logic [31:0] InstrRetired;

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .IllegalOp(IllegalOp),
    .MemTimeout(MemTimeout), .InstrRetired(InstrRetired)
  );

  always #5 Clock = ~Clock;

  typedef struct { logic [5:0] op; logic zero; int cycles; } vec_t;
  vec_t tbl[6];

  int          total = 0, bad = 0;
  logic [31:0] model_ret = 0;
  logic        exp_to = 1'b0;
  logic        pend_ill = 1'b0;
  logic        cur_zero;
  int          plan_ret;
  logic [15:0] exp_q[$];
  logic        rdy_q[$];
  logic [5:0]  op_q[$];

  function automatic logic [16:0] act();
    return {MemTimeout, IllegalOp, MemReq, MemWrite, IorD, IRWrite, PCWrite, RegWrite,
            RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op == T_R || op == T_LW || op == T_SW || op == T_BEQ || op == T_ADDI || op == T_J;
  endfunction

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic push(input logic [14:0] e, input logic r, input logic [5:0] o);
    exp_q.push_back({pend_ill, e});
    rdy_q.push_back(r);
    op_q.push_back(o);
    pend_ill = 1'b0;
  endtask

  // Instruction-level model: expand one instruction into its per-cycle control words
  task automatic plan(input logic [5:0] op, input logic z, input int fw, input int mw);
    exp_q.delete(); rdy_q.delete(); op_q.delete();
    cur_zero = z;
    for (int i = 0; i < fw; i++) push(FW, 1'b0, op);
    push(FR, 1'b1, op);
    push(DEC, 1'($urandom), op);
    case (op)
      T_R:    begin push(EXE, 1'($urandom), 6'($urandom)); push(WBR, 1'($urandom), 6'($urandom)); end
      T_ADDI: begin push(MADR, 1'($urandom), 6'($urandom)); push(WBI, 1'($urandom), 6'($urandom)); end
      T_LW: begin
        push(MADR, 1'($urandom), 6'($urandom));
        for (int i = 0; i < mw; i++) push(MRD, 1'b0, 6'($urandom));
        push(MRD, 1'b1, 6'($urandom));
        push(MWB, 1'($urandom), 6'($urandom));
      end
      T_SW: begin
        push(MADR, 1'($urandom), 6'($urandom));
        for (int i = 0; i < mw; i++) push(MWR, 1'b0, 6'($urandom));
        push(MWR, 1'b1, 6'($urandom));
      end
      T_BEQ:  push(z ? BR1 : BR0, 1'($urandom), 6'($urandom));
      T_J:    push(JMP, 1'($urandom), 6'($urandom));
      default: ;
    endcase
    plan_ret = is_legal(op) ? 1 : 0;
    pend_ill = !is_legal(op);
  endtask

  task automatic run_plan();
    Zero = cur_zero;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      MemReady = rdy_q[i];
      Opcode   = op_q[i];
      #1;
      if (i == 0) check("retired", InstrRetired, model_ret);
      check($sformatf("ctrl op=%b step=%0d", op_q[0], i), 32'(act()), 32'({exp_to, exp_q[i]}));
    end
    model_ret += 32'(plan_ret);
  endtask

  task automatic cyc(input logic r, input logic [5:0] o, input logic [14:0] e, input string nm);
    @(negedge Clock);
    MemReady = r;
    Opcode   = o;
    #1;
    check(nm, 32'(act()), 32'({exp_to, 1'b0, e}));
  endtask

  // Run one instruction with MemReady high, counting cycles until FETCH shows up again
  task automatic measure(input logic [5:0] op, input logic z, output int n);
    Opcode = op;
    Zero   = z;
    n      = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      MemReady = 1'b1;
      #1;
      if (i > 0 && MemReq && !IorD) begin
        MemReady = 1'b0;
        break;
      end
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [5:0] op;
    logic [5:0] legal[6];

    tbl[0] = '{T_R, 1'b0, 4};
    tbl[1] = '{T_LW, 1'b0, 5};
    tbl[2] = '{T_SW, 1'b0, 4};
    tbl[3] = '{T_BEQ, 1'b1, 3};
    tbl[4] = '{T_ADDI, 1'b0, 4};
    tbl[5] = '{T_J, 1'b0, 3};
    legal = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_J};

    // Reset held: all outputs low
    repeat (2) @(negedge Clock);
    #1;
    check("rst_outs", 32'(act()), 32'd0);
    check("rst_ret", InstrRetired, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    MemReady = 1'b0;
    #1;
    check("post_rst_fetch", 32'(act()), 32'({2'b00, FW}));

    // Reset mid-MEMRD with MemReady low aborts back to FETCH
    cyc(1'b1, T_LW, FR, "lw_fetch");
    cyc(1'b0, T_LW, DEC, "lw_dec");
    cyc(1'b0, 6'h3f, MADR, "lw_madr");
    cyc(1'b0, 6'h3f, MRD, "lw_memrd");
    Reset = 1'b1;
    #1;
    check("midrst_outs", 32'(act()), 32'd0);
    check("midrst_ret", InstrRetired, 32'd0);
    @(negedge Clock);
    #1;
    check("midrst_outs2", 32'(act()), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    MemReady = 1'b0;
    #1;
    check("midrst_fetch", 32'(act()), 32'({2'b00, FW}));

    // Cycles per instruction with MemReady tied high
    foreach (tbl[i]) begin
      measure(tbl[i].op, tbl[i].zero, n);
      check($sformatf("cycles op=%b", tbl[i].op), 32'(n), 32'(tbl[i].cycles));
    end
    check("retired_six", InstrRetired, 32'd6);
    model_ret = 32'd6;

    // Exact control words for each instruction, no waits
    foreach (tbl[i]) begin
      plan(tbl[i].op, tbl[i].zero, 0, 0);
      run_plan();
    end

    // FETCH waits 3 cycles before IR/PC write
    plan(T_R, 1'b0, 3, 0);
    run_plan();

    // beq not taken then taken
    plan(T_BEQ, 1'b0, 0, 0);
    run_plan();
    plan(T_BEQ, 1'b1, 0, 0);
    run_plan();

    // Random instruction stream with random memory latency
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 6) == 6) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else begin
        op = legal[$urandom_range(0, 5)];
      end
      plan(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      run_plan();
    end
    plan(T_J, 1'b0, 0, 0);
    run_plan();

    // MemReady stuck low in MEMWR: timeout after 15 wait cycles, no retire
    cyc(1'b1, T_SW, FR, "to_fetch");
    cyc(1'b1, T_SW, DEC, "to_dec");
    cyc(1'b1, 6'h00, MADR, "to_madr");
    for (int i = 0; i < 15; i++) cyc(1'b0, 6'($urandom), MWR, $sformatf("to_memwr%0d", i));
    exp_to = 1'b1;
    cyc(1'b0, T_SW, FW, "to_back_fetch");
    check("to_ret", InstrRetired, model_ret);

    // Illegal opcode: one-cycle pulse, no retire
    plan(6'b111111, 1'b0, 0, 0);
    run_plan();
    plan(T_J, 1'b0, 1, 0);
    run_plan();
    plan(T_ADDI, 1'b0, 0, 0);
    run_plan();
    @(negedge Clock);
    #1;
    check("final_ret", InstrRetired, model_ret);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
